// File: rtl/demux_chan_deser_if.sv
// rtl/demux_chan_deser_if.sv - strobe/data/ack bundle between demux driver and channel deserializer
interface demux_chan_deser_if #(
  parameter int WIDTH = 8
);
  logic                 stb;
  logic [1:0]           s;
  logic [3:0]           y;
  logic [3:0]           ack;
  logic [4*WIDTH-1:0]   dout;
  logic [3:0]           valid;
  logic [3:0]           ovf;
  logic                 err;

  modport master (
    output stb, s, y, ack,
    input  dout, valid, ovf, err
  );

  modport slave (
    input  stb, s, y, ack,
    output dout, valid, ovf, err
  );
endinterface

// File: rtl/demux_chan_deser.sv
// rtl/demux_chan_deser.sv - four-channel bit-serial deserializer behind a 1x4 demux (optional checker: DEMUX_CHK_EN)
module demux_chan_deser #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  demux_chan_deser_if.slave   bus
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q   [4];
  logic [WIDTH-1:0] sr_d   [4];
  logic [CW-1:0]    cnt_q  [4];
  logic [CW-1:0]    cnt_d  [4];
  logic [WIDTH-1:0] word_q [4];
  logic [WIDTH-1:0] word_d [4];
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       ovf_q,   ovf_d;

  // Per-channel shift, completion and ack handling; only the selected channel moves on a strobe.
  always_comb begin
    valid_d = valid_q;
    ovf_d   = ovf_q;
    for (int c = 0; c < 4; c++) begin
      sr_d[c]   = sr_q[c];
      cnt_d[c]  = cnt_q[c];
      word_d[c] = word_q[c];
    end
    for (int c = 0; c < 4; c++) begin
      if (bus.stb && (bus.s == 2'(c))) begin
        sr_d[c] = {sr_q[c][WIDTH-2:0], bus.y[c]};
        if (cnt_q[c] == LAST) begin
          cnt_d[c] = '0;
          // A pending word is only replaced when the consumer frees it this same cycle.
          if (!valid_q[c] || bus.ack[c]) begin
            word_d[c]  = {sr_q[c][WIDTH-2:0], bus.y[c]};
            valid_d[c] = 1'b1;
            ovf_d[c]   = 1'b0;
          end else begin
            ovf_d[c] = 1'b1;
          end
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
          if (bus.ack[c]) begin
            valid_d[c] = 1'b0;
            ovf_d[c]   = 1'b0;
          end
        end
      end else if (bus.ack[c]) begin
        valid_d[c] = 1'b0;
        ovf_d[c]   = 1'b0;
      end
    end
  end

  // Channel state registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        sr_q[c]   <= '0;
        cnt_q[c]  <= '0;
        word_q[c] <= '0;
      end
      valid_q <= '0;
      ovf_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_dout
    assign bus.dout[n*WIDTH +: WIDTH] = word_q[n];
  end

  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;

`ifdef DEMUX_CHK_EN
  logic err_q, err_d;

  // A strobe with any non-selected demux line high means the demux and our select disagree.
  always_comb begin
    err_d = err_q;
    if (bus.stb && |(bus.y & ~(4'b0001 << bus.s))) begin
      err_d = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_chan_deser.sv
// tb/tb_demux_chan_deser.sv - directed self-checking bench for demux_chan_deser
module tb_demux_chan_deser;

  localparam int W = 8;
`ifdef DEMUX_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  demux_chan_deser_if #(.WIDTH(W)) bus ();

  demux_chan_deser #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input int ch, input logic b, input logic [3:0] ackv);
    bus.s   = 2'(ch);
    bus.y   = b ? (4'b0001 << ch) : 4'b0000;
    bus.ack = ackv;
    bus.stb = 1'b1;
    @(posedge clk);
    #1;
    bus.stb = 1'b0;
    bus.y   = 4'b0000;
    bus.ack = 4'b0000;
  endtask

  // Sends the top n bits of w, MSB first; last_ack rides along with the final bit.
  task automatic send_word(input int ch, input logic [7:0] w, input int n, input logic [3:0] last_ack);
    for (int i = 7; i > 7 - n; i--) begin
      send_bit(ch, w[i], (i == 8 - n) ? last_ack : 4'b0000);
    end
  endtask

  task automatic pulse_ack(input logic [3:0] a);
    bus.ack = a;
    @(posedge clk);
    #1;
    bus.ack = 4'b0000;
  endtask

  initial begin
    logic [7:0] w0;
    logic [7:0] w1;
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    bus.stb = 1'b0;
    bus.s   = 2'd0;
    bus.y   = 4'b0000;
    bus.ack = 4'b0000;
    #1;
    check("rst_dout",  bus.dout,  32'h0);
    check("rst_valid", bus.valid, 4'b0000);
    check("rst_ovf",   bus.ovf,   4'b0000);
    check("rst_err",   bus.err,   1'b0);
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 0xA5 on channel 2
    send_word(2, 8'hA5, 7, 4'b0000);
    check("a5_valid_7bits", bus.valid, 4'b0000);
    send_word(2, 8'hA5 << 7, 1, 4'b0000);
    check("a5_dout_ch2", bus.dout[23:16], 8'hA5);
    check("a5_dout_all", bus.dout, 32'h00A50000);
    check("a5_valid",    bus.valid, 4'b0100);
    pulse_ack(4'b0100);
    check("a5_ack_valid", bus.valid, 4'b0000);

    // Interleaved channels 0 and 3
    w0 = 8'h3C;
    w1 = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      send_bit(0, w0[i], 4'b0000);
      send_bit(3, w1[i], 4'b0000);
    end
    check("il_dout", bus.dout, 32'hC3A5003C);
    check("il_valid", bus.valid, 4'b1001);
    check("il_ovf", bus.ovf, 4'b0000);
    check("il_err", bus.err, 1'b0);
    pulse_ack(4'b1111);
    check("il_ackall_valid", bus.valid, 4'b0000);

    // Overflow on channel 1
    send_word(1, 8'h11, 8, 4'b0000);
    check("ov_first_valid", bus.valid, 4'b0010);
    send_word(1, 8'h22, 8, 4'b0000);
    check("ov_dout_kept", bus.dout[15:8], 8'h11);
    check("ov_valid", bus.valid, 4'b0010);
    check("ov_ovf", bus.ovf, 4'b0010);
    pulse_ack(4'b0010);
    check("ov_ack_valid", bus.valid, 4'b0000);
    check("ov_ack_ovf", bus.ovf, 4'b0000);
    check("ov_ack_dout", bus.dout[15:8], 8'h11);

    // Completion coincident with ack on channel 0
    send_word(0, 8'h0F, 8, 4'b0000);
    check("co_first_dout", bus.dout[7:0], 8'h0F);
    send_word(0, 8'hF0, 8, 4'b0001);
    check("co_dout", bus.dout[7:0], 8'hF0);
    check("co_valid", bus.valid, 4'b0001);
    check("co_ovf", bus.ovf, 4'b0000);
    pulse_ack(4'b0001);

    // Reset mid-word on channel 1
    send_word(1, 8'hFF, 5, 4'b0000);
    #1;
    rst = 1'b1;
    #1;
    check("mr_dout", bus.dout, 32'h0);
    check("mr_valid", bus.valid, 4'b0000);
    check("mr_ovf", bus.ovf, 4'b0000);
    check("mr_err", bus.err, 1'b0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_word(1, 8'h81, 7, 4'b0000);
    check("mr_7bits_valid", bus.valid, 4'b0000);
    send_word(1, 8'h81 << 7, 1, 4'b0000);
    check("mr_dout_ch1", bus.dout, 32'h00008100);
    check("mr_valid_ch1", bus.valid, 4'b0010);

    // Demux consistency checker
    bus.s   = 2'd0;
    bus.y   = 4'b0010;
    bus.stb = 1'b1;
    @(posedge clk);
    #1;
    bus.stb = 1'b0;
    bus.y   = 4'b0000;
    check("ck_err_set", bus.err, EXP_ERR);
    send_bit(0, 1'b0, 4'b0000);
    send_bit(2, 1'b1, 4'b0000);
    check("ck_err_sticky", bus.err, EXP_ERR);
    rst = 1'b1;
    #1;
    check("ck_err_rst", bus.err, 1'b0);
    #2;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
